riscv_core_icache_ctrl: RTL and testbench
=========================================

Name: riscv_core_icache_ctrl

Overview:
- Controller for the instruction-cache data array: holds the tag/valid arrays, detects hit/miss per fetch, and sequences AXI block refills into the data array.
- Handles 32-bit fetches that straddle two 32-byte blocks (RVC alignment), with up to two refills per fetch.
- Sits between the core fetch stage, the icache data array and the AXI read master.

Parameters:
- ADDR_WIDTH, 64, fetch/AXI address width
- INDEX_WIDTH, 7, set index bits (addr[11:5]); 128 sets, direct-mapped
- TAG_WIDTH, 52, tag bits (addr[63:12])
- BLOCK_OFFSET_WIDTH, 3, word-in-block bits (addr[4:2]); 32-byte block
- AXI_DATA_WIDTH, 256, refill beat width (one beat = one block)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_fetch_req  in  1  core requests instruction at i_fetch_addr
- i_fetch_addr  in  ADDR_WIDTH  fetch byte address, halfword aligned; held stable while o_fetch_stall=1
- i_flush  in  1  fence.i: invalidate all lines
- o_instr_valid  out  1  data array output valid for core this cycle
- o_fetch_stall  out  1  fetch not served this cycle
- o_fetch_err  out  1  one-cycle pulse: refill returned error
- o_mem_rd_en  out  1  data array read enable
- o_mem_wr_en  out  1  data array write enable
- o_mem_block_replace  out  1  data array block replace
- o_mem_offset  out  1  0: write block of addr; 1: write block of addr+2
- o_axi_rd_req  out  1  refill request, level, held until i_axi_rd_valid
- o_axi_rd_addr  out  ADDR_WIDTH  block-aligned refill address (low 5 bits zero)
- i_axi_rd_valid  in  1  refill block present on data array input this cycle
- i_axi_rd_err  in  1  qualifies i_axi_rd_valid: refill failed

Behaviour:
- Tag RAM: TAG_WIDTH x 128 flops; valid: 128-bit flop vector. Reset: all valid=0, FSM=IDLE, all outputs 0.
- Block0 = set of addr[11:5]; block1 = set of (addr+2)[11:5]. span = (addr[4:0]==5'd30).
- hit0 = valid[idx0] & tag[idx0]==addr[63:12]; hit1 uses addr+2 fields; hit = hit0 & (!span | hit1).
- FSM states: IDLE, REFILL0, REFILL1, FLUSH.
- IDLE, i_fetch_req & hit: combinational o_mem_rd_en=1, o_instr_valid=1, stall=0; zero-cycle hit latency.
- IDLE, i_fetch_req & miss: stall=1, instr_valid=0. Next state is REFILL0 if !hit0, else REFILL1.
- REFILL0: o_axi_rd_req=1, o_axi_rd_addr={addr[63:5],5'b0}, stall=1.
  - On i_axi_rd_valid & !err: wr_en=block_replace=1, offset=0; tag/valid[idx0] updated.
  - Next state: REFILL1 if span & !hit1 (evaluated after update), else IDLE.
- REFILL1: same as REFILL0 with address (addr+2) block-aligned, offset=1, updates idx1; then IDLE.
- If idx0==idx1 (cannot occur with span, since idx1=idx0+1 mod 128): set 127 wraps to set 0, which is required to work.
- Hit is re-evaluated in IDLE the cycle after refill, so miss penalty = AXI latency + 1 cycle per block.
- i_axi_rd_valid & i_axi_rd_err: no write, no valid set, o_fetch_err pulses 1 cycle, go to IDLE. Core decides retry or trap.
- i_axi_rd_valid outside REFILL0/1: ignored.
- i_flush in IDLE: valid cleared next edge; that cycle stall=1 and instr_valid=0 even on hit.
- i_flush during REFILL: latched as pending; the refill completes, then FLUSH state clears all valid (1 cycle), then IDLE.
- i_flush and completing refill in the same cycle: the flush wins, and the filled line ends invalid.
- Reset mid-refill: FSM to IDLE, o_axi_rd_req drops next edge, valid cleared. The AXI master must discard an outstanding beat on reset.
- !i_fetch_req in IDLE: rd_en=0, stall=0, instr_valid=0.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined: adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0].
  - Hit counter increments on each IDLE cycle with i_fetch_req & hit.
  - Miss counter increments on each IDLE->REFILL transition.
  - Both are cleared by i_rst and wrap at 2^32.
- Not defined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset, fetch 0x1000 -> stall, o_axi_rd_req=1 with addr 0x1000; i_axi_rd_valid after 3 cycles -> wr_en/offset=0 pulse, next cycle o_instr_valid=1 with stall=0.
- Refill 0x1000 block, then fetch 0x1004, 0x101C -> o_instr_valid=1 each cycle, no AXI request.
- Cold fetch 0x103E (span) -> refills 0x1020 (offset=0), then 0x1040 (offset=1), then hit; only 0x1040 refilled if 0x1020 already valid.
- Fetch 0x1FFE (span, set 127 -> set 0) -> refills 0x1FE0 then 0x2000, then hit.
- Miss at 0x3000 with i_axi_rd_err=1 -> o_fetch_err 1-cycle pulse, no write, refetch 0x3000 misses again.
- Fill 0x1000, assert i_flush during a refill of 0x5000 -> after FLUSH, fetches of 0x1000 and 0x5000 both miss.

Source files
------------

// File: rtl/riscv_core_icache_ctrl_if.sv
// Fetch/data-array/AXI-refill signal bundle for the icache controller.
// The slave modport is the controller; the master modport is its environment.
interface riscv_core_icache_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  i_fetch_req;
  logic [ADDR_WIDTH-1:0] i_fetch_addr;
  logic                  i_flush;
  logic                  o_instr_valid;
  logic                  o_fetch_stall;
  logic                  o_fetch_err;
  logic                  o_mem_rd_en;
  logic                  o_mem_wr_en;
  logic                  o_mem_block_replace;
  logic                  o_mem_offset;
  logic                  o_axi_rd_req;
  logic [ADDR_WIDTH-1:0] o_axi_rd_addr;
  logic                  i_axi_rd_valid;
  logic                  i_axi_rd_err;

  modport slave (
    input  i_fetch_req, i_fetch_addr, i_flush, i_axi_rd_valid, i_axi_rd_err,
    output o_instr_valid, o_fetch_stall, o_fetch_err, o_mem_rd_en, o_mem_wr_en,
           o_mem_block_replace, o_mem_offset, o_axi_rd_req, o_axi_rd_addr
  );

  modport master (
    output i_fetch_req, i_fetch_addr, i_flush, i_axi_rd_valid, i_axi_rd_err,
    input  o_instr_valid, o_fetch_stall, o_fetch_err, o_mem_rd_en, o_mem_wr_en,
           o_mem_block_replace, o_mem_offset, o_axi_rd_req, o_axi_rd_addr
  );
endinterface

// File: rtl/riscv_core_icache_ctrl.sv
// Direct-mapped icache controller: tag/valid arrays, hit detection and block refill sequencing.
// Optional hit/miss counters are enabled with the ICACHE_PERF_CNT_EN macro.
module riscv_core_icache_ctrl #(
  parameter int ADDR_WIDTH         = 64,
  parameter int INDEX_WIDTH        = 7,
  parameter int TAG_WIDTH          = 52,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int AXI_DATA_WIDTH     = 256
) (
  input logic                     i_clk,
  input logic                     i_rst,
  riscv_core_icache_ctrl_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]             o_hit_cnt,
  output logic [31:0]             o_miss_cnt
`endif
);
  localparam int BLOCK_LSB  = BLOCK_OFFSET_WIDTH + 2;
  localparam int BLK_WIDTH  = ADDR_WIDTH - BLOCK_LSB;
  localparam int NUM_SETS   = 1 << INDEX_WIDTH;
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam logic [BLOCK_LSB-1:0] SPAN_OFFSET = BLOCK_LSB'(BEAT_BYTES - 2);

  typedef enum logic [1:0] {IDLE, REFILL0, REFILL1, FLUSH} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [BLK_WIDTH-1:0]   blk0, blk1;
  logic [INDEX_WIDTH-1:0] idx0, idx1;
  logic [TAG_WIDTH-1:0]   tag0, tag1;
  logic                   span, hit0, hit1, hit;
  logic                   flush_pend_reg, flush_pend_next;
  logic                   valid_clr, fill_en, miss_evt;
  logic [INDEX_WIDTH-1:0] fill_idx;
  logic [TAG_WIDTH-1:0]   fill_tag;

  logic [TAG_WIDTH-1:0]   tag_reg [NUM_SETS];
  logic [NUM_SETS-1:0]    valid_reg;

  // The fetch address is only guaranteed stable while stalled, so refills use the captured copy.
  assign cur_addr = (state_reg == IDLE) ? bus.i_fetch_addr : addr_reg;

  // Fetches are halfword aligned, so addr+2 leaves the block only when the fetch spans.
  assign span = (cur_addr[BLOCK_LSB-1:0] == SPAN_OFFSET);
  assign blk0 = cur_addr[ADDR_WIDTH-1:BLOCK_LSB];
  assign blk1 = blk0 + BLK_WIDTH'(span);
  assign idx0 = blk0[INDEX_WIDTH-1:0];
  assign idx1 = blk1[INDEX_WIDTH-1:0];
  assign tag0 = blk0[BLK_WIDTH-1 -: TAG_WIDTH];
  assign tag1 = blk1[BLK_WIDTH-1 -: TAG_WIDTH];

  assign hit0 = valid_reg[idx0] && (tag_reg[idx0] == tag0);
  assign hit1 = valid_reg[idx1] && (tag_reg[idx1] == tag1);
  assign hit  = hit0 && (!span || hit1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      flush_pend_reg <= 1'b0;
      addr_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      flush_pend_reg <= flush_pend_next;
      if (miss_evt) begin
        addr_reg <= bus.i_fetch_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_en) begin
      tag_reg[fill_idx] <= fill_tag;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
      always_ff @(posedge i_clk) begin
        if (i_rst || valid_clr) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_en && (fill_idx == INDEX_WIDTH'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next              = state_reg;
    flush_pend_next         = flush_pend_reg;
    bus.o_instr_valid       = 1'b0;
    bus.o_fetch_stall       = 1'b0;
    bus.o_fetch_err         = 1'b0;
    bus.o_mem_rd_en         = 1'b0;
    bus.o_mem_wr_en         = 1'b0;
    bus.o_mem_block_replace = 1'b0;
    bus.o_mem_offset        = 1'b0;
    bus.o_axi_rd_req        = 1'b0;
    bus.o_axi_rd_addr       = '0;
    valid_clr               = 1'b0;
    fill_en                 = 1'b0;
    fill_idx                = idx0;
    fill_tag                = tag0;
    miss_evt                = 1'b0;
    case (state_reg)
      IDLE: begin
        flush_pend_next = 1'b0;
        if (bus.i_flush) begin
          bus.o_fetch_stall = 1'b1;
          valid_clr         = 1'b1;
        end else if (bus.i_fetch_req) begin
          if (hit) begin
            bus.o_mem_rd_en   = 1'b1;
            bus.o_instr_valid = 1'b1;
          end else begin
            bus.o_fetch_stall = 1'b1;
            miss_evt          = 1'b1;
            state_next        = hit0 ? REFILL1 : REFILL0;
          end
        end
      end
      REFILL0, REFILL1: begin
        bus.o_fetch_stall = 1'b1;
        bus.o_axi_rd_req  = 1'b1;
        flush_pend_next   = flush_pend_reg | bus.i_flush;
        bus.o_axi_rd_addr = (state_reg == REFILL0) ? {blk0, {BLOCK_LSB{1'b0}}}
                                                   : {blk1, {BLOCK_LSB{1'b0}}};
        if (bus.i_axi_rd_valid) begin
          if (bus.i_axi_rd_err) begin
            bus.o_fetch_err = 1'b1;
          end else begin
            bus.o_mem_wr_en         = 1'b1;
            bus.o_mem_block_replace = 1'b1;
            bus.o_mem_offset        = (state_reg == REFILL1);
            fill_en                 = 1'b1;
            fill_idx                = (state_reg == REFILL1) ? idx1 : idx0;
            fill_tag                = (state_reg == REFILL1) ? tag1 : tag0;
          end
          // A flush seen at any point of the refill wipes the just-filled line too.
          if (flush_pend_next) begin
            state_next = FLUSH;
          end else if (!bus.i_axi_rd_err && (state_reg == REFILL0) && span && !hit1) begin
            state_next = REFILL1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      FLUSH: begin
        bus.o_fetch_stall = 1'b1;
        valid_clr         = 1'b1;
        flush_pend_next   = 1'b0;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef ICACHE_PERF_CNT_EN
  logic        hit_evt;
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  assign hit_evt = (state_reg == IDLE) && bus.i_fetch_req && hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (hit_evt) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_evt) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_reg;
  assign o_miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_riscv_core_icache_ctrl.sv
// Directed bench for riscv_core_icache_ctrl: a per-cycle vector table plus a mid-refill reset sequence.
module tb_riscv_core_icache_ctrl;
  localparam int AW = 64;

  // Expected output bits: {instr_valid, stall, fetch_err, rd_en, wr_en, offset, axi_req}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_HIT   = 7'b1001000;
  localparam logic [6:0] E_STALL = 7'b0100000;
  localparam logic [6:0] E_REQ   = 7'b0100001;
  localparam logic [6:0] E_WR0   = 7'b0100101;
  localparam logic [6:0] E_WR1   = 7'b0100111;
  localparam logic [6:0] E_ERR   = 7'b0110001;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          flush;
    logic          av;
    logic          ae;
    logic [6:0]    exp;
    logic [AW-1:0] aaddr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_core_icache_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  riscv_core_icache_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
`endif
  );

  int total  = 0;
  int passed = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic [AW-1:0] addr, input logic fl,
                              input logic av, input logic ae, input logic [6:0] exp,
                              input logic [AW-1:0] aaddr);
    vec_t v;
    v.req = req; v.addr = addr; v.flush = fl; v.av = av; v.ae = ae;
    v.exp = exp; v.aaddr = aaddr;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input logic req, input logic [AW-1:0] addr, input logic fl,
                       input logic av, input logic ae);
    @(posedge clk);
    #1;
    bus.i_fetch_req    = req;
    bus.i_fetch_addr   = addr;
    bus.i_flush        = fl;
    bus.i_axi_rd_valid = av;
    bus.i_axi_rd_err   = ae;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    check("instr_valid", idx, 64'(bus.o_instr_valid), 64'(v.exp[6]));
    check("fetch_stall", idx, 64'(bus.o_fetch_stall), 64'(v.exp[5]));
    check("fetch_err", idx, 64'(bus.o_fetch_err), 64'(v.exp[4]));
    check("mem_rd_en", idx, 64'(bus.o_mem_rd_en), 64'(v.exp[3]));
    check("mem_wr_en", idx, 64'(bus.o_mem_wr_en), 64'(v.exp[2]));
    check("block_replace", idx, 64'(bus.o_mem_block_replace), 64'(v.exp[2]));
    check("mem_offset", idx, 64'(bus.o_mem_offset), 64'(v.exp[1]));
    check("axi_rd_req", idx, 64'(bus.o_axi_rd_req), 64'(v.exp[0]));
    if (v.exp[0]) check("axi_rd_addr", idx, bus.o_axi_rd_addr, v.aaddr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_req;
    bus.i_fetch_req = 0; bus.i_fetch_addr = '0; bus.i_flush = 0;
    bus.i_axi_rd_valid = 0; bus.i_axi_rd_err = 0;

    // cold miss, 3-cycle AXI wait, then hits within the block
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_REQ,   'h1000));
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_REQ,   'h1000));
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_REQ,   'h1000));
    vecs.push_back(mk(1, 'h1000, 0, 1, 0, E_WR0,   'h1000));
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_HIT,   0));
    vecs.push_back(mk(1, 'h1004, 0, 0, 0, E_HIT,   0));
    vecs.push_back(mk(1, 'h101C, 0, 0, 0, E_HIT,   0));
    vecs.push_back(mk(0, 'h0,    0, 0, 0, E_NONE,  0));
    // spanning fetch, both blocks cold
    vecs.push_back(mk(1, 'h103E, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h103E, 0, 1, 0, E_WR0,   'h1020));
    vecs.push_back(mk(1, 'h103E, 0, 0, 0, E_REQ,   'h1040));
    vecs.push_back(mk(1, 'h103E, 0, 1, 0, E_WR1,   'h1040));
    vecs.push_back(mk(1, 'h103E, 0, 0, 0, E_HIT,   0));
    // spanning fetch, first block already present
    vecs.push_back(mk(1, 'h105E, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h105E, 0, 1, 0, E_WR1,   'h1060));
    vecs.push_back(mk(1, 'h105E, 0, 0, 0, E_HIT,   0));
    // set 127 -> set 0 wrap
    vecs.push_back(mk(1, 'h1FFE, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h1FFE, 0, 1, 0, E_WR0,   'h1FE0));
    vecs.push_back(mk(1, 'h1FFE, 0, 1, 0, E_WR1,   'h2000));
    vecs.push_back(mk(1, 'h1FFE, 0, 0, 0, E_HIT,   0));
    // refill error, pulse for one cycle, refetch misses again
    vecs.push_back(mk(1, 'h3000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h3000, 0, 1, 1, E_ERR,   'h3000));
    vecs.push_back(mk(1, 'h3000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h3000, 0, 1, 0, E_WR0,   'h3000));
    vecs.push_back(mk(0, 'h0,    0, 0, 0, E_NONE,  0));
    // fill 0x1000, flush during 0x5000 refill
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h1000, 0, 1, 0, E_WR0,   'h1000));
    vecs.push_back(mk(1, 'h1000, 0, 0, 0, E_HIT,   0));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 1, 0, 0, E_REQ,   'h5000));
    vecs.push_back(mk(1, 'h5000, 0, 1, 0, E_WR0,   'h5000));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 0, 1, 0, E_WR0,   'h5000));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_HIT,   0));
    // flush in IDLE on a hit, then flush together with refill completion
    vecs.push_back(mk(1, 'h5000, 1, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 1, 1, 0, E_WR0,   'h5000));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h5000, 0, 1, 0, E_WR0,   'h5000));
    // set 1 was valid before the flushes, must miss now
    vecs.push_back(mk(1, 'h1020, 0, 0, 0, E_STALL, 0));
    vecs.push_back(mk(1, 'h1020, 0, 1, 0, E_WR0,   'h1020));
    // stray beat in IDLE is ignored
    vecs.push_back(mk(0, 'h0,    0, 1, 0, E_NONE,  0));
    vecs.push_back(mk(1, 'h1020, 0, 0, 0, E_HIT,   0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_instr_valid", -1, 64'(bus.o_instr_valid), 64'd0);
    check("reset_stall", -1, 64'(bus.o_fetch_stall), 64'd0);
    check("reset_axi_req", -1, 64'(bus.o_axi_rd_req), 64'd0);
    check("reset_wr_en", -1, 64'(bus.o_mem_wr_en), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].flush, vecs[i].av, vecs[i].ae);
      @(negedge clk);
      check_vec(i, vecs[i]);
      $display("step %0d: req=%0b addr=0x%0h flush=%0b av=%0b ae=%0b -> iv=%0b st=%0b wr=%0b off=%0b arq=%0b araddr=0x%0h",
               i, vecs[i].req, vecs[i].addr, vecs[i].flush, vecs[i].av, vecs[i].ae,
               bus.o_instr_valid, bus.o_fetch_stall, bus.o_mem_wr_en, bus.o_mem_offset,
               bus.o_axi_rd_req, bus.o_axi_rd_addr);
    end

`ifdef ICACHE_PERF_CNT_EN
    @(posedge clk);
    #1;
    check("hit_cnt", -1, 64'(hit_cnt), 64'd10);
    check("miss_cnt", -1, 64'(miss_cnt), 64'd12);
`endif

    // reset in the middle of a refill
    drive(1, 'h7000, 0, 0, 0);
    @(negedge clk);
    check("rst_seq_miss_stall", 100, 64'(bus.o_fetch_stall), 64'd1);
    seen_req = 0;
    for (int c = 0; c < 8 && !seen_req; c++) begin
      drive(1, 'h7000, 0, 0, 0);
      @(negedge clk);
      seen_req = bus.o_axi_rd_req;
    end
    check("rst_seq_axi_req_seen", 101, 64'(seen_req), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_fetch_req = 0;
    @(negedge clk);
    check("rst_seq_axi_req_drop", 102, 64'(bus.o_axi_rd_req), 64'd0);
    check("rst_seq_stall", 102, 64'(bus.o_fetch_stall), 64'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_seq_hit_cnt", 102, 64'(hit_cnt), 64'd0);
    check("rst_seq_miss_cnt", 102, 64'(miss_cnt), 64'd0);
`endif
    $display("step 102: reset mid-refill -> arq=%0b st=%0b", bus.o_axi_rd_req, bus.o_fetch_stall);
    drive(1, 'h1020, 0, 0, 0);
    @(negedge clk);
    check("rst_seq_valid_cleared", 103, 64'(bus.o_instr_valid), 64'd0);
    check("rst_seq_refetch_stall", 103, 64'(bus.o_fetch_stall), 64'd1);
    $display("step 103: fetch 0x1020 after reset -> iv=%0b st=%0b", bus.o_instr_valid, bus.o_fetch_stall);
    drive(0, 'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
